// File: rtl/guess_game_ctrl.sv
// Sequencing FSM for the number-guessing game: seeds, scores guesses, declares win/lose.
// Latency: state, LEDs and tries update on the edge that samples an Enter press.
// No backpressure: Enter presses are single-cycle events, flags are sampled the same cycle.
module guess_game_ctrl #(
  parameter int unsigned MAX_TRIES = 8,
  parameter int unsigned CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enter,
  input  logic             i_over,
  input  logic             i_under,
  input  logic             i_equal,
  output logic             o_inc_actual,
  output logic             o_led_over,
  output logic             o_led_under,
  output logic             o_led_equal,
  output logic [CNT_W-1:0] o_tries,
  output logic [1:0]       o_state,
  output logic             o_win,
  output logic             o_lose
);

  typedef enum logic [1:0] {
    SEED  = 2'd0,
    GUESS = 2'd1,
    WIN   = 2'd2,
    LOSE  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tries_q, tries_d;
  logic             led_over_q, led_over_d;
  logic             led_under_q, led_under_d;
  logic             led_equal_q, led_equal_d;
  logic             enter_q;
  logic             press;
  logic [CNT_W-1:0] tries_inc;

  // enter_q resets high so a button held through reset never yields a press.
  assign press     = i_enter & ~enter_q;
  assign tries_inc = tries_q + ONE_C;

  // Enter edge-detect history register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enter_q <= 1'b1;
    end else begin
      enter_q <= i_enter;
    end
  end

  // State, attempt counter and result LEDs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= SEED;
      tries_q     <= '0;
      led_over_q  <= 1'b0;
      led_under_q <= 1'b0;
      led_equal_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tries_q     <= tries_d;
      led_over_q  <= led_over_d;
      led_under_q <= led_under_d;
      led_equal_q <= led_equal_d;
    end
  end

  // Next-state logic: score guesses in GUESS, clear everything when leaving WIN/LOSE.
  always_comb begin
    state_d     = state_q;
    tries_d     = tries_q;
    led_over_d  = led_over_q;
    led_under_d = led_under_q;
    led_equal_d = led_equal_q;
    case (state_q)
      SEED: begin
        if (press) begin
          state_d = GUESS;
        end
      end
      GUESS: begin
        if (press) begin
          tries_d     = tries_inc;
          led_over_d  = 1'b0;
          led_under_d = 1'b0;
          led_equal_d = 1'b0;
          // Priority equal > over > under; no flag at all scores as under.
          if (i_equal) begin
            led_equal_d = 1'b1;
          end else if (i_over) begin
            led_over_d = 1'b1;
          end else begin
            led_under_d = 1'b1;
          end
          if (i_equal) begin
            state_d = WIN;
          end else if (tries_inc == MAX_C) begin
            state_d = LOSE;
          end
        end
      end
      WIN, LOSE: begin
        if (press) begin
          state_d     = SEED;
          tries_d     = '0;
          led_over_d  = 1'b0;
          led_under_d = 1'b0;
          led_equal_d = 1'b0;
        end
      end
      default: begin
        state_d = SEED;
      end
    endcase
  end

  // Outputs decoded straight from registered state; the datapath keeps
  // incrementing through the SEED->GUESS press cycle.
  always_comb begin
    o_inc_actual = (state_q == SEED);
    o_win        = (state_q == WIN);
    o_lose       = (state_q == LOSE);
    o_state      = state_q;
    o_tries      = tries_q;
    o_led_over   = led_over_q;
    o_led_under  = led_under_q;
    o_led_equal  = led_equal_q;
  end

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Random-stimulus bench for guess_game_ctrl with a scoreboard against a game-rule model.
// Latency: expected outputs are checked one clock edge after each stimulus cycle.
// No backpressure: the monitor compares every cycle in which an expectation is queued.
module tb_guess_game_ctrl;

  localparam int MAX_TRIES = 8;
  localparam int CNT_W     = 4;

  logic             clk;
  logic             reset;
  logic             i_enter;
  logic             i_over;
  logic             i_under;
  logic             i_equal;
  logic             o_inc_actual;
  logic             o_led_over;
  logic             o_led_under;
  logic             o_led_equal;
  logic [CNT_W-1:0] o_tries;
  logic [1:0]       o_state;
  logic             o_win;
  logic             o_lose;

  guess_game_ctrl #(.MAX_TRIES(MAX_TRIES), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .i_enter      (i_enter),
    .i_over       (i_over),
    .i_under      (i_under),
    .i_equal      (i_equal),
    .o_inc_actual (o_inc_actual),
    .o_led_over   (o_led_over),
    .o_led_under  (o_led_under),
    .o_led_equal  (o_led_equal),
    .o_tries      (o_tries),
    .o_state      (o_state),
    .o_win        (o_win),
    .o_lose       (o_lose)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  logic [11:0] exp_q[$];
  int n_win  = 0;
  int n_lose = 0;

  // Reference game: phase names the round stage (0 seed, 1 guessing, 2 won, 3 lost).
  int   m_phase;
  int   m_tries;
  bit   m_lo, m_lu, m_le;
  bit   m_prev;

  function automatic logic [11:0] model_vec(int phase, int tries, bit lo, bit lu, bit le);
    logic [1:0] ph;
    logic [3:0] tr;
    ph = phase[1:0];
    tr = tries[3:0];
    return {ph, (phase == 0), lo, lu, le, tr, (phase == 2), (phase == 3)};
  endfunction

  function automatic logic [11:0] dut_vec();
    return {o_state, o_inc_actual, o_led_over, o_led_under, o_led_equal, o_tries, o_win, o_lose};
  endfunction

  task automatic check(string name, logic [11:0] act, logic [11:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %b expected %b (state,inc,over,under,equal,tries,win,lose)",
               name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_tries = 0; m_lo = 0; m_lu = 0; m_le = 0; m_prev = 1;
  endtask

  // One clock edge of the game rules, applied to the inputs present this cycle.
  task automatic model_step(bit enter, bit ov, bit un, bit eq);
    bit press;
    press  = enter && !m_prev;
    m_prev = enter;
    if (!press) return;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      m_tries = m_tries + 1;
      m_le = eq;
      m_lo = !eq && ov;
      m_lu = !eq && !ov;
      if (eq) begin
        m_phase = 2;
        n_win++;
      end else if (m_tries == MAX_TRIES) begin
        m_phase = 3;
        n_lose++;
      end
    end else begin
      m_phase = 0; m_tries = 0; m_lo = 0; m_lu = 0; m_le = 0;
    end
  endtask

  // Monitor: after every rising edge, compare outputs with the queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("cycle", dut_vec(), exp_q.pop_front());
    end
  end

  bit reset_done = 0;

  initial begin
    reset = 1'b1; i_enter = 1'b1; i_over = 0; i_under = 0; i_equal = 0;
    model_reset();
    #2;
    check("reset_vals", dut_vec(), model_vec(0, 0, 0, 0, 0));
    // Enter held through reset and beyond: no press until released.
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      model_step(i_enter, i_over, i_under, i_equal);
      exp_q.push_back(model_vec(m_phase, m_tries, m_lo, m_lu, m_le));
      @(negedge clk);
    end
    i_enter = 1'b0;
    model_step(i_enter, i_over, i_under, i_equal);
    exp_q.push_back(model_vec(m_phase, m_tries, m_lo, m_lu, m_le));
    @(negedge clk);
    i_enter = 1'b1;
    check("seed_press_inc", {11'd0, o_inc_actual}, 12'd1);
    model_step(i_enter, i_over, i_under, i_equal);
    exp_q.push_back(model_vec(m_phase, m_tries, m_lo, m_lu, m_le));
    @(negedge clk);
    check("seed_to_guess", {10'd0, o_state}, 12'd1);

    // Randomized play.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 3) == 0) i_enter = ~i_enter;
      case ($urandom_range(0, 9))
        0:       {i_over, i_under, i_equal} = 3'b001;
        1:       {i_over, i_under, i_equal} = 3'b000;
        2:       {i_over, i_under, i_equal} = 3'($urandom_range(0, 7));
        3, 4, 5: {i_over, i_under, i_equal} = 3'b100;
        default: {i_over, i_under, i_equal} = 3'b010;
      endcase
      if (!reset_done && m_phase == 1 && m_tries == 4) begin
        // Asynchronous reset between edges in the middle of a round.
        reset_done = 1;
        i_enter = 1'b1;
        #2 reset = 1'b1;
        #1 check("async_reset", dut_vec(), model_vec(0, 0, 0, 0, 0));
        model_reset();
        @(negedge clk);
        reset = 1'b0;
      end else begin
        model_step(i_enter, i_over, i_under, i_equal);
        exp_q.push_back(model_vec(m_phase, m_tries, m_lo, m_lu, m_le));
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (!reset_done || n_win == 0 || n_lose == 0)
      $display("note: coverage thin (reset=%0d wins=%0d losses=%0d)", reset_done, n_win, n_lose);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
